// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter in front of a single shared memory port
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [3:0]      ls_be,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   timeout_cnt;
    logic            owner_ls;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;

    logic            fetch_wins;
    logic            grant_if;
    logic            grant_ls;
    logic            resp_fire;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    // Arbitration: load-store has priority until the fetch side has been passed over STARVE_LIMIT times
    always_comb begin
        fetch_wins = if_req && (!ls_req || (starve_cnt == STARVE_MAX));
        grant_if   = !rst && (state == IDLE) && fetch_wins;
        grant_ls   = !rst && (state == IDLE) && ls_req && !fetch_wins;
        // A real response in the timeout cycle takes precedence over the synthesized error
        resp_fire  = (state == WAIT_RESP) && (mem_rvalid || (timeout_cnt == TIMEOUT_MAX));
        resp_data  = mem_rvalid ? mem_rdata : '0;
        resp_err   = mem_rvalid ? mem_err : 1'b1;
    end

    // Output decode: responses are routed to the owner only, everything else stays 0
    always_comb begin
        if_gnt    = grant_if;
        ls_gnt    = grant_ls;
        if_rvalid = resp_fire && !owner_ls;
        ls_rvalid = resp_fire && owner_ls;
        if_rdata  = if_rvalid ? resp_data : '0;
        if_err    = if_rvalid && resp_err;
        ls_rdata  = ls_rvalid ? resp_data : '0;
        ls_err    = ls_rvalid && resp_err;
        mem_req   = (state == ISSUE);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
    end

    // Transaction FSM: capture the winner, hold the request until accepted, then wait for the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            owner_ls    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        state    <= ISSUE;
                        owner_ls <= 1'b1;
                        we_q     <= ls_we;
                        addr_q   <= ls_addr;
                        wdata_q  <= ls_wdata;
                        be_q     <= ls_be;
                    end else if (grant_if) begin
                        state    <= ISSUE;
                        owner_ls <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= if_addr;
                        wdata_q  <= '0;
                        be_q     <= 4'hF;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        state       <= WAIT_RESP;
                        timeout_cnt <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (resp_fire) begin
                        state <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Starvation counter: counts load-store wins while a fetch is waiting, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if || !if_req) begin
            starve_cnt <= '0;
        end else if (grant_ls && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            if_err;
    logic            ls_req;
    logic            ls_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic [3:0]      ls_be;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            ls_err;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_err;

    mem_port_arbiter #(
        .XLEN(XLEN),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one outstanding transaction record plus the cycle it was accepted
    int          now = 0;
    bit          busy = 1'b0;
    bit          accepted = 1'b0;
    int          t_accept = 0;
    int          streak = 0;
    bit          m_ls = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    bit          e_if_gnt, e_ls_gnt, e_resp;

    logic        obs_if_gnt, obs_ls_gnt, obs_if_rvalid, obs_ls_rvalid, obs_ls_err, obs_mem_req;
    logic [31:0] obs_if_rdata, obs_mem_addr;

    int p_if, p_ls, p_ready, p_spur, lat_max;
    int lat = 0;
    int glog[$];
    int tlog[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // One clock cycle: inputs already set, compare outputs with the model, advance the model, cross the edge
    task automatic cycle();
        logic [31:0] rd;
        logic        er;
        logic [127:0] e_ifr, e_lsr;
        #2;
        obs_if_gnt = if_gnt; obs_ls_gnt = ls_gnt;
        obs_if_rvalid = if_rvalid; obs_ls_rvalid = ls_rvalid; obs_ls_err = ls_err;
        obs_mem_req = mem_req; obs_if_rdata = if_rdata; obs_mem_addr = mem_addr;
        e_if_gnt = 1'b0; e_ls_gnt = 1'b0; e_resp = 1'b0;
        if (rst) begin
            busy = 1'b0; accepted = 1'b0; streak = 0;
            check("rst_rsp", {if_gnt, ls_gnt, if_rvalid, if_err, if_rdata, ls_rvalid, ls_err, ls_rdata}, '0);
            check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, '0);
        end else begin
            if (!busy && (if_req || ls_req)) begin
                if (ls_req && !(if_req && streak >= STARVE_LIMIT)) e_ls_gnt = 1'b1;
                else e_if_gnt = 1'b1;
            end
            check("gnt", {if_gnt, ls_gnt}, {e_if_gnt, e_ls_gnt});
            check("mem_req", mem_req, busy && !accepted);
            if (busy && !accepted)
                check("mem_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {m_we, m_addr, m_wdata, m_be});
            if (busy && accepted) e_resp = mem_rvalid || ((now - t_accept - 1) == TIMEOUT);
            rd = mem_rvalid ? mem_rdata : 32'h0;
            er = mem_rvalid ? mem_err : 1'b1;
            e_ifr = (e_resp && !m_ls) ? {1'b1, er, rd} : '0;
            e_lsr = (e_resp && m_ls) ? {1'b1, er, rd} : '0;
            check("if_rsp", {if_rvalid, if_err, if_rdata}, e_ifr);
            check("ls_rsp", {ls_rvalid, ls_err, ls_rdata}, e_lsr);
            if (e_resp) busy = 1'b0;
            if (busy && !accepted && mem_ready) begin
                accepted = 1'b1;
                t_accept = now;
            end
            if (e_ls_gnt) begin
                busy = 1'b1; accepted = 1'b0; m_ls = 1'b1;
                m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_be;
            end else if (e_if_gnt) begin
                busy = 1'b1; accepted = 1'b0; m_ls = 1'b0;
                m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
            end
            if (e_if_gnt || !if_req) streak = 0;
            else if (e_ls_gnt && streak < STARVE_LIMIT) streak++;
        end
        now++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    task automatic knobs(input int pi, input int pl, input int pr, input int ps, input int lm);
        p_if = pi; p_ls = pl; p_ready = pr; p_spur = ps; lat_max = lm;
    endtask

    // Randomized requesters and memory; requesters hold req until the model says they were granted
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = int'($urandom_range(99)) < p_ready;
            mem_rdata = $urandom;
            mem_err   = 1'($urandom_range(1));
            if (busy && accepted) mem_rvalid = ((now - t_accept - 1) == lat);
            else mem_rvalid = int'($urandom_range(99)) < p_spur;
            cycle();
            if (obs_ls_gnt) begin glog.push_back(1); tlog.push_back(now - 1); end
            if (obs_if_gnt) begin glog.push_back(2); tlog.push_back(now - 1); end
            if (busy && accepted && t_accept == now - 1) lat = int'($urandom_range(lat_max));
            if (e_if_gnt) if_req = 0;
            if (e_ls_gnt) ls_req = 0;
            if (!if_req && int'($urandom_range(99)) < p_if) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req && int'($urandom_range(99)) < p_ls) begin
                ls_req = 1; ls_we = 1'($urandom_range(1)); ls_addr = $urandom;
                ls_wdata = $urandom; ls_be = 4'($urandom_range(15));
            end
        end
    endtask

    task automatic drain();
        knobs(0, 0, 100, 0, 0);
        run(25);
        quiet();
    endtask

    function automatic int glog_code(input int n);
        int c = 0;
        for (int i = 0; i < n && i < glog.size(); i++) c = c * 10 + glog[i];
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, hit, gap;
        logic herr;

        quiet();
        rst = 1'b1;
        if_req = 1; ls_req = 1; mem_rvalid = 1;
        cycle();
        cycle();
        quiet();
        rst = 1'b0;

        // single fetch, response two cycles after issue
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        cycle();
        check("t043_if_gnt", obs_if_gnt, 1'b1);
        if_req = 0;
        cycle();
        check("t043_mem_req", {obs_mem_req, obs_mem_addr}, {1'b1, 32'h100});
        cycle();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        check("t043_rdata", {obs_if_rvalid, obs_if_rdata, obs_ls_rvalid}, {1'b1, 32'hDEADBEEF, 1'b0});
        quiet();
        cycle();

        // simultaneous requests: load-store first, fetch on the regrant three cycles later
        glog.delete(); tlog.delete();
        knobs(0, 0, 100, 0, 0);
        if_req = 1; if_addr = 32'h104;
        ls_req = 1; ls_we = 0; ls_addr = 32'h200; ls_be = 4'hF;
        run(8);
        gap = (tlog.size() >= 2) ? tlog[1] - tlog[0] : -1;
        check("t044_count", glog.size(), 2);
        check("t044_order", glog_code(2), 12);
        check("t044_gap", gap, 3);
        drain();

        // starvation: continuous load-store traffic with a waiting fetch
        glog.delete(); tlog.delete();
        knobs(0, 100, 100, 0, 0);
        if_req = 1; if_addr = 32'h700;
        ls_req = 1; ls_we = 1; ls_addr = 32'h800; ls_wdata = 32'h1; ls_be = 4'hF;
        run(15);
        check("t045_order", glog_code(5), 11112);
        check("t045_starve", dut.starve_cnt, 0);
        drain();

        // store held in ISSUE while memory is not ready
        ls_req = 1; ls_we = 1; ls_addr = 32'h300; ls_wdata = 32'hCAFE0001; ls_be = 4'b0011;
        cycle();
        ls_req = 0;
        nreq = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            cycle();
            nreq += int'(obs_mem_req);
        end
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        cycle();
        check("t046_hold", nreq, 4);
        check("t046_rvalid", obs_ls_rvalid, 1'b1);
        quiet();
        cycle();

        // no response: timeout error exactly TIMEOUT cycles into the wait
        ls_req = 1; ls_we = 0; ls_addr = 32'h400; mem_ready = 1;
        cycle();
        ls_req = 0;
        cycle();
        mem_ready = 0;
        hit = -1; herr = 1'b0;
        for (int k = 0; k <= TIMEOUT + 2; k++) begin
            cycle();
            if (obs_ls_rvalid && hit < 0) begin hit = k; herr = obs_ls_err; end
        end
        check("t047_lat", hit, TIMEOUT);
        check("t047_err", herr, 1'b1);

        // reset during the wait, then a stale response
        ls_req = 1; ls_addr = 32'h500; mem_ready = 1;
        cycle();
        ls_req = 0;
        cycle();
        mem_ready = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        cycle();
        check("t048_stale", {obs_if_rvalid, obs_ls_rvalid}, 2'b00);
        quiet();
        glog.delete(); tlog.delete();
        knobs(0, 0, 100, 0, 0);
        if_req = 1; if_addr = 32'h600;
        run(6);
        check("t048_regrant", glog_code(3), 2);
        drain();

        // randomized traffic with occasional resets
        knobs(40, 50, 60, 10, TIMEOUT + 2);
        for (int c = 0; c < 4; c++) begin
            run(700);
            rst = 1;
            cycle();
            rst = 0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4, max consecutive load-store grants while a fetch waits.
REQ-003 Parameter TIMEOUT, default 15, max cycles to wait for mem_rvalid after a grant.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  fetch request, held until if_gnt.
REQ-007 if_addr  in  XLEN  fetch word address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch response valid, 1-cycle pulse.
REQ-010 if_rdata  out  XLEN  fetch data, valid with if_rvalid.
REQ-011 if_err  out  1  fetch error, valid with if_rvalid.
REQ-012 ls_req  in  1  load-store request, held until ls_gnt.
REQ-013 ls_we  in  1  1 = store, 0 = load.
REQ-014 ls_addr  in  XLEN  load-store address.
REQ-015 ls_wdata  in  XLEN  store data.
REQ-016 ls_be  in  4  byte enables.
REQ-017 ls_gnt  out  1  load-store request accepted this cycle.
REQ-018 ls_rvalid  out  1  load-store response valid, 1-cycle pulse; also asserted for stores.
REQ-019 ls_rdata  out  XLEN  load data.
REQ-020 ls_err  out  1  load-store error.
REQ-021 mem_req  out  1  request to the shared memory.
REQ-022 mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/4  request fields.
REQ-023 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-024 mem_rvalid  in  1  memory response.
REQ-025 mem_rdata  in  XLEN  memory read data.
REQ-026 mem_err  in  1  memory address error.

Function
REQ-027 FSM states: IDLE, ISSUE, WAIT_RESP; at most one transaction outstanding.
REQ-028 IDLE: if any request is pending, select the winner and go to ISSUE the next cycle; selection registers owner, we, addr, wdata, be.
REQ-029 Priority: ls_req beats if_req, unless starve_cnt == STARVE_LIMIT and if_req = 1, in which case fetch wins.
REQ-030 starve_cnt: increments on an ls grant while if_req = 1, clears on an if grant or when if_req = 0, and saturates at STARVE_LIMIT.
REQ-031 if_gnt/ls_gnt pulse for exactly one cycle in the IDLE->ISSUE transition cycle; the two grants are never high together.
REQ-032 ISSUE: mem_req = 1 with the registered fields, held stable until mem_ready; on mem_ready go to WAIT_RESP and clear timeout_cnt.
REQ-033 WAIT_RESP: on mem_rvalid, pulse the owner's rvalid with rdata = mem_rdata and err = mem_err, then go to IDLE.
REQ-034 The earliest regrant is the cycle after rvalid; back-to-back throughput is one transaction per 3 cycles with zero-latency memory.
REQ-035 timeout_cnt counts cycles in WAIT_RESP; at TIMEOUT without mem_rvalid, pulse the owner's rvalid with err = 1 and rdata = 0, then go to IDLE.
REQ-036 If mem_rvalid arrives in the same cycle the timeout is reached, the real response wins and err = mem_err.
REQ-037 A mem_rvalid in IDLE or ISSUE is ignored; no rvalid is forwarded.
REQ-038 Non-owner rvalid/rdata/err are 0 at all times.
REQ-039 A requester dropping req before its grant is a protocol violation; the arbiter evaluates requests only in IDLE.

Reset
REQ-040 While rst = 1, the FSM is IDLE, starve_cnt = 0, timeout_cnt = 0, and the registered fields are 0.
REQ-041 While rst = 1, all outputs are 0.
REQ-042 Reset mid-transaction abandons the transaction with no rvalid; a late mem_rvalid after reset is ignored per REQ-037.

Verification
REQ-043 if_req = 1 with addr 0x100, mem_ready = 1, mem_rvalid 2 cycles after issue with rdata 0xDEADBEEF -> if_gnt at cycle 1, mem_req at cycle 2, if_rvalid with 0xDEADBEEF, ls outputs 0.
REQ-044 if_req and ls_req both high at the same cycle -> ls_gnt first, if_gnt on the next regrant.
REQ-045 ls_req held high continuously, if_req high, STARVE_LIMIT = 4 -> four ls grants, fifth grant to fetch, starve_cnt back to 0.
REQ-046 Store with ls_be = 4'b0011 and mem_ready low for 3 cycles -> mem_req and fields stable for 4 cycles, ls_rvalid after mem_rvalid.
REQ-047 No mem_rvalid after a grant -> ls_rvalid with ls_err = 1 exactly TIMEOUT cycles into WAIT_RESP, FSM back to IDLE.
REQ-048 rst pulsed during WAIT_RESP, then mem_rvalid -> no rvalid to either side, all outputs 0, next request served normally.
